// File: rtl/sram_pkg.sv
// Shared types and constants for the dual-requester SQI SRAM arbiter.
package sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_DONE  = 3'd5
  } sqi_state_e;

  localparam logic [7:0] CMD_WRITE_DEF = 8'h02;
  localparam logic [7:0] CMD_READ_DEF  = 8'h03;

  localparam logic [2:0] NIB_CMD   = 3'd2;
  localparam logic [2:0] NIB_ADDR  = 3'd6;
  localparam logic [2:0] NIB_DUMMY = 3'd2;
  localparam logic [2:0] NIB_DATA  = 3'd2;

  // Index of the final nibble of a shifting state
  function automatic logic [2:0] last_nibble(input sqi_state_e st);
    case (st)
      ST_CMD:   last_nibble = NIB_CMD - 3'd1;
      ST_ADDR:  last_nibble = NIB_ADDR - 3'd1;
      ST_DUMMY: last_nibble = NIB_DUMMY - 3'd1;
      ST_DATA:  last_nibble = NIB_DATA - 3'd1;
      default:  last_nibble = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/sqi_byte_engine.sv
// Runs one single-byte SQI read or write: command, 24-bit address, dummy
// byte on reads, then data. All pin outputs come straight from registers.
module sqi_byte_engine
  import sram_pkg::*;
#(
  parameter logic [7:0] CMD_WRITE = CMD_WRITE_DEF,
  parameter logic [7:0] CMD_READ  = CMD_READ_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        we,
  input  logic [23:0] addr24,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        sram_clock,
  output logic        sram_cs,
  output logic [3:0]  sram_sio_o,
  output logic        sram_sio_oe,
  input  logic [3:0]  sram_sio_i
);

  sqi_state_e  state_r, state_s, after_s;
  logic        phase_r, phase_s;
  logic [2:0]  cnt_r, cnt_s;
  logic [39:0] sh_r, sh_s;
  logic        we_r, we_s;
  logic [3:0]  rd_hi_r, rd_hi_s;
  logic [7:0]  rdata_r, rdata_s;
  logic        done_r, done_s;
  logic        cs_r, cs_s;
  logic        sclk_r, sclk_s;
  logic        oe_r, oe_s;
  logic [3:0]  sio_r, sio_s;
  logic [7:0]  cmd_s;

  // Next state and next pin values; sh holds the nibbles still to be sent
  always_comb begin
    state_s = state_r;
    phase_s = phase_r;
    cnt_s   = cnt_r;
    sh_s    = sh_r;
    we_s    = we_r;
    rd_hi_s = rd_hi_r;
    rdata_s = rdata_r;
    done_s  = 1'b0;
    cs_s    = cs_r;
    sclk_s  = 1'b0;
    oe_s    = oe_r;
    sio_s   = sio_r;
    cmd_s   = we ? CMD_WRITE : CMD_READ;
    case (state_r)
      ST_CMD:   after_s = ST_ADDR;
      ST_ADDR:  after_s = we_r ? ST_DATA : ST_DUMMY;
      ST_DUMMY: after_s = ST_DATA;
      ST_DATA:  after_s = ST_DONE;
      default:  after_s = ST_IDLE;
    endcase
    case (state_r)
      ST_IDLE: begin
        cs_s = 1'b1;
        oe_s = 1'b0;
        if (start) begin
          state_s = ST_CMD;
          phase_s = 1'b0;
          cnt_s   = 3'd0;
          we_s    = we;
          cs_s    = 1'b0;
          oe_s    = 1'b1;
          sio_s   = cmd_s[7:4];
          sh_s    = {cmd_s[3:0], addr24, wdata, 4'h0};
        end else begin
          sio_s = 4'h0;
        end
      end
      ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
        if (!phase_r) begin
          phase_s = 1'b1;
          sclk_s  = 1'b1;
        end else begin
          phase_s = 1'b0;
          // Read data is captured on the edge that drops sram_clock
          if (state_r == ST_DATA && !we_r) begin
            if (cnt_r == 3'd0) begin
              rd_hi_s = sram_sio_i;
            end else begin
              rdata_s = {rd_hi_r, sram_sio_i};
            end
          end else begin
            rd_hi_s = rd_hi_r;
          end
          if (cnt_r == last_nibble(state_r)) begin
            cnt_s   = 3'd0;
            state_s = after_s;
          end else begin
            cnt_s = cnt_r + 3'd1;
          end
          if (state_s == ST_DONE) begin
            cs_s   = 1'b1;
            oe_s   = 1'b0;
            done_s = 1'b1;
            sio_s  = 4'h0;
          end else if (state_s == ST_DUMMY || (state_s == ST_DATA && !we_r)) begin
            oe_s  = 1'b0;
            sio_s = 4'h0;
          end else begin
            sio_s = sh_r[39:36];
            sh_s  = {sh_r[35:0], 4'h0};
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        cs_s    = 1'b1;
        oe_s    = 1'b0;
        sio_s   = 4'h0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      phase_r <= 1'b0;
      cnt_r   <= 3'd0;
      sh_r    <= 40'd0;
      we_r    <= 1'b0;
      rd_hi_r <= 4'h0;
      rdata_r <= 8'h00;
      done_r  <= 1'b0;
      cs_r    <= 1'b1;
      sclk_r  <= 1'b0;
      oe_r    <= 1'b0;
      sio_r   <= 4'h0;
    end else begin
      state_r <= state_s;
      phase_r <= phase_s;
      cnt_r   <= cnt_s;
      sh_r    <= sh_s;
      we_r    <= we_s;
      rd_hi_r <= rd_hi_s;
      rdata_r <= rdata_s;
      done_r  <= done_s;
      cs_r    <= cs_s;
      sclk_r  <= sclk_s;
      oe_r    <= oe_s;
      sio_r   <= sio_s;
    end
  end

  assign busy        = (state_r != ST_IDLE);
  assign done        = done_r;
  assign rdata       = rdata_r;
  assign sram_clock  = sclk_r;
  assign sram_cs     = cs_r;
  assign sram_sio_o  = sio_r;
  assign sram_sio_oe = oe_r;

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SQI SRAM between two requesters; each
// grant becomes a single-byte transaction run by sqi_byte_engine.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int         ADDR_WIDTH = 17,
  parameter logic [7:0] CMD_WRITE  = CMD_WRITE_DEF,
  parameter logic [7:0] CMD_READ   = CMD_READ_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [7:0]            wdata0,
  input  logic [7:0]            wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [7:0]            rdata,
  output logic                  sram_clock,
  output logic                  sram_cs,
  output logic [3:0]            sram_sio_o,
  output logic                  sram_sio_oe,
  input  logic [3:0]            sram_sio_i
);

  logic        busy_s, eng_done_s, start_s;
  logic        grant0_s, grant1_s;
  logic        gnt0_r, gnt1_r, owner_r, last_r;
  logic        op_we_s;
  logic [23:0] op_addr_s;
  logic [7:0]  op_wdata_s;

  // Pick a requester while the engine is idle; ties go to the one not served last
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!busy_s) begin
      if (req0 && req1) begin
        grant0_s = last_r;
        grant1_s = !last_r;
      end else begin
        grant0_s = req0;
        grant1_s = req1;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign start_s = grant0_s | grant1_s;

  // Operands of the requester being granted this cycle
  always_comb begin
    op_we_s    = 1'b0;
    op_addr_s  = 24'd0;
    op_wdata_s = 8'h00;
    if (grant1_s) begin
      op_we_s    = we1;
      op_addr_s  = 24'(addr1);
      op_wdata_s = wdata1;
    end else begin
      op_we_s    = we0;
      op_addr_s  = 24'(addr0);
      op_wdata_s = wdata0;
    end
  end

  // Grant pulses, owner of the running transaction and round-robin history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      owner_r <= 1'b0;
      last_r  <= 1'b1;
    end else begin
      gnt0_r <= grant0_s;
      gnt1_r <= grant1_s;
      if (start_s) begin
        owner_r <= grant1_s;
      end
      if (eng_done_s) begin
        last_r <= owner_r;
      end
    end
  end

  sqi_byte_engine #(
    .CMD_WRITE (CMD_WRITE),
    .CMD_READ  (CMD_READ)
  ) u_engine (
    .clock       (clock),
    .reset       (reset),
    .start       (start_s),
    .we          (op_we_s),
    .addr24      (op_addr_s),
    .wdata       (op_wdata_s),
    .busy        (busy_s),
    .done        (eng_done_s),
    .rdata       (rdata),
    .sram_clock  (sram_clock),
    .sram_cs     (sram_cs),
    .sram_sio_o  (sram_sio_o),
    .sram_sio_oe (sram_sio_oe),
    .sram_sio_i  (sram_sio_i)
  );

  assign gnt0  = gnt0_r;
  assign gnt1  = gnt1_r;
  assign done0 = eng_done_s & ~owner_r;
  assign done1 = eng_done_s & owner_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: vector table, arbitration sequences,
// reset abort, and random traffic against a memory reference model.
module tb_sram_arbiter;

  localparam logic [7:0] CMD_W = 8'h02;
  localparam logic [7:0] CMD_R = 8'h03;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [16:0] addr0 = 17'd0, addr1 = 17'd0;
  logic [7:0]  wdata0 = 8'h00, wdata1 = 8'h00;
  logic        gnt0, gnt1, done0, done1;
  logic [7:0]  rdata;
  logic        sram_clock, sram_cs, sram_sio_oe;
  logic [3:0]  sram_sio_o;
  logic [3:0]  sram_sio_i;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;
  int gnt_port_q[$], gnt_cyc_q[$], done_port_q[$];

  // SQI SRAM model state
  logic [7:0]  sram_mem [logic [23:0]];
  logic [7:0]  ref_mem  [logic [16:0]];
  int          nib_n, m_recs, oe_viol;
  logic [7:0]  m_cmd, m_data, rd_byte;
  logic [23:0] m_addr;

  typedef struct {
    bit          port;
    bit          we;
    logic [16:0] addr;
    logic [7:0]  wdata;
    bit          preload;
    logic [7:0]  pre_val;
    int          exp_lat;
    int          exp_oe;
    logic [7:0]  exp_data;
  } vec_t;

  sram_arbiter dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
    .sram_clock(sram_clock), .sram_cs(sram_cs), .sram_sio_o(sram_sio_o),
    .sram_sio_oe(sram_sio_oe), .sram_sio_i(sram_sio_i)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] init_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mem_read(input logic [23:0] a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return init_byte(a);
  endfunction

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  // Event log plus exclusivity of grant and done pulses
  initial begin
    forever begin
      @(negedge clock);
      if (gnt0 || gnt1) begin
        chk("gnt_exclusive", 64'(gnt0 && gnt1), 64'd0);
        gnt_port_q.push_back(int'(gnt1));
        gnt_cyc_q.push_back(cyc);
      end
      if (done0 || done1) begin
        chk("done_exclusive", 64'(done0 && done1), 64'd0);
        done_port_q.push_back(int'(done1));
      end
    end
  end

  // SRAM device: decodes nibbles on rising sram_clock, answers reads
  initial begin
    nib_n = 0; m_recs = 0; oe_viol = 0; sram_sio_i = 4'h0;
    forever begin
      @(posedge sram_clock or posedge sram_cs);
      if (sram_cs) begin
        nib_n = 0;
      end else begin
        if (nib_n < 2) begin
          m_cmd = {m_cmd[3:0], sram_sio_o};
          if (!sram_sio_oe) oe_viol++;
        end else if (nib_n < 8) begin
          m_addr = {m_addr[19:0], sram_sio_o};
          if (!sram_sio_oe) oe_viol++;
        end else if (m_cmd == CMD_W) begin
          if (!sram_sio_oe) oe_viol++;
          if (nib_n < 10) m_data = {m_data[3:0], sram_sio_o};
          if (nib_n == 9) begin sram_mem[m_addr] = m_data; m_recs++; end
        end else begin
          if (sram_sio_oe) oe_viol++;
          if (nib_n == 9) rd_byte = mem_read(m_addr);
          if (nib_n == 10) sram_sio_i = rd_byte[7:4];
          if (nib_n == 11) begin sram_sio_i = rd_byte[3:0]; m_data = rd_byte; m_recs++; end
        end
        nib_n++;
      end
    end
  end

  task automatic clear_logs();
    gnt_port_q.delete(); gnt_cyc_q.delete(); done_port_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic do_txn(input bit port, input bit we, input logic [16:0] a, input logic [7:0] wd,
                        output int lat, output int oe_low, output logic [7:0] rd);
    int g;
    bit got;
    lat = -1; oe_low = -1; rd = 8'h00; got = 1'b0;
    @(posedge clock); #1;
    if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
    else begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (port ? gnt1 : gnt0) got = 1'b1;
    end
    if (port) req1 = 1'b0; else req0 = 1'b0;
    if (!got) begin chk("gnt_timeout", 64'd0, 64'd1); return; end
    g = cyc; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      if (!sram_sio_oe && oe_low < 0) oe_low = cyc - g;
      if (port ? done1 : done0) begin got = 1'b1; lat = cyc - g; rd = rdata; end
    end
    if (!got) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_check(input string tag, input bit port, input bit we, input logic [16:0] a,
                           input logic [7:0] wd, input int exp_lat, input int exp_oe,
                           input logic [7:0] exp_data);
    int lat, oe_low, recs0;
    logic [7:0] rd;
    clear_logs();
    recs0 = m_recs;
    do_txn(port, we, a, wd, lat, oe_low, rd);
    @(negedge clock);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_oe_drop"}, 64'(oe_low), 64'(exp_oe));
    chk({tag, "_gnt_pulses"}, 64'(gnt_port_q.size()), 64'd1);
    chk({tag, "_done_port"}, 64'(done_port_q.size() == 1 ? done_port_q[0] : 2), 64'(port));
    chk({tag, "_sram_txns"}, 64'(m_recs - recs0), 64'd1);
    chk({tag, "_bus"}, 64'({m_cmd, m_addr, m_data}), 64'({(we ? CMD_W : CMD_R), 24'(a), exp_data}));
    if (!we) chk({tag, "_rdata"}, 64'(rd), 64'(exp_data));
  endtask

  initial begin
    vec_t vecs [7];
    logic [16:0] pool [6];
    int lat, oe_low, exp_p, last, n1;
    logic [7:0] rd, exp_rd, wd;
    logic [16:0] a;
    bit port, we;

    vecs[0] = '{port:1'b0, we:1'b1, addr:17'h12345, wdata:8'hA5, preload:1'b0, pre_val:8'h00, exp_lat:20, exp_oe:20, exp_data:8'hA5};
    vecs[1] = '{port:1'b1, we:1'b0, addr:17'h00010, wdata:8'h00, preload:1'b1, pre_val:8'h3C, exp_lat:24, exp_oe:16, exp_data:8'h3C};
    vecs[2] = '{port:1'b1, we:1'b1, addr:17'h1FFFF, wdata:8'h5A, preload:1'b0, pre_val:8'h00, exp_lat:20, exp_oe:20, exp_data:8'h5A};
    vecs[3] = '{port:1'b0, we:1'b0, addr:17'h1FFFF, wdata:8'h00, preload:1'b0, pre_val:8'h00, exp_lat:24, exp_oe:16, exp_data:8'h5A};
    vecs[4] = '{port:1'b0, we:1'b1, addr:17'h00000, wdata:8'hFF, preload:1'b0, pre_val:8'h00, exp_lat:20, exp_oe:20, exp_data:8'hFF};
    vecs[5] = '{port:1'b1, we:1'b0, addr:17'h00000, wdata:8'h00, preload:1'b0, pre_val:8'h00, exp_lat:24, exp_oe:16, exp_data:8'hFF};
    vecs[6] = '{port:1'b0, we:1'b0, addr:17'h0ABCD, wdata:8'h00, preload:1'b1, pre_val:8'h00, exp_lat:24, exp_oe:16, exp_data:8'h00};

    repeat (2) @(negedge clock);
    chk("reset_outputs",
        64'({gnt0, gnt1, done0, done1, sram_cs, sram_clock, sram_sio_oe, sram_sio_o, rdata}),
        64'({4'b0000, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00}));
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].preload) sram_mem[24'(vecs[i].addr)] = vecs[i].pre_val;
      run_check($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp_lat, vecs[i].exp_oe, vecs[i].exp_data);
    end

    // Both requesters held high after reset: round-robin from port 0, 22-cycle period
    do_reset();
    clear_logs();
    we0 = 1'b1; we1 = 1'b1; addr0 = 17'h00100; addr1 = 17'h00200;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 400 && gnt_port_q.size() < 5; i++) @(negedge clock);
    req0 = 1'b0; req1 = 1'b0;
    chk("tie_grant_count", 64'(gnt_port_q.size()), 64'd5);
    last = 1;
    for (int k = 0; k < gnt_port_q.size() && k < 5; k++) begin
      exp_p = (last == 1) ? 0 : 1;
      last = exp_p;
      chk($sformatf("tie_port%0d", k), 64'(gnt_port_q[k]), 64'(exp_p));
      if (k > 0) chk($sformatf("tie_period%0d", k), 64'(gnt_cyc_q[k] - gnt_cyc_q[k-1]), 64'd22);
    end
    repeat (30) @(negedge clock);

    // Port 1 alone, held high: served every 22 cycles, never a gnt0
    clear_logs();
    we1 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 300 && gnt_port_q.size() < 3; i++) @(negedge clock);
    req1 = 1'b0;
    chk("solo_grant_count", 64'(gnt_port_q.size()), 64'd3);
    for (int k = 0; k < gnt_port_q.size() && k < 3; k++) begin
      chk($sformatf("solo_port%0d", k), 64'(gnt_port_q[k]), 64'd1);
      if (k > 0) chk($sformatf("solo_period%0d", k), 64'(gnt_cyc_q[k] - gnt_cyc_q[k-1]), 64'd22);
    end
    repeat (30) @(negedge clock);

    // req1 pulsed for one cycle while port 0 is busy: never served
    clear_logs();
    fork
      do_txn(1'b0, 1'b1, 17'h00300, 8'h11, lat, oe_low, rd);
      begin
        repeat (5) @(negedge clock);
        we1 = 1'b1; req1 = 1'b1;
        @(negedge clock);
        req1 = 1'b0;
      end
    join
    repeat (40) @(negedge clock);
    chk("drop_busy_latency", 64'(lat), 64'd20);
    n1 = 0;
    foreach (gnt_port_q[k]) if (gnt_port_q[k] == 1) n1++;
    foreach (done_port_q[k]) if (done_port_q[k] == 1) n1++;
    chk("drop_no_port1_events", 64'(n1), 64'd0);

    // Reset in cycle 9 of a write: pins return to idle at once, no done
    clear_logs();
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 17'h00400; wdata0 = 8'h77;
    for (int i = 0; i < 50 && gnt_port_q.size() == 0; i++) @(negedge clock);
    req0 = 1'b0;
    chk("abort_granted", 64'(gnt_port_q.size()), 64'd1);
    repeat (9) @(negedge clock);
    chk("abort_sclk_high_before", 64'(sram_clock), 64'd1);
    #2 reset = 1'b1;
    #1 chk("abort_pins_async", 64'({sram_cs, sram_clock, sram_sio_oe, gnt0, done0}), 64'(5'b10000));
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    chk("abort_no_done", 64'(done_port_q.size()), 64'd0);
    chk("abort_not_stored", 64'(sram_mem.exists(24'h000400)), 64'd0);
    run_check("after_reset", 1'b0, 1'b1, 17'h00500, 8'h66, 20, 20, 8'h66);

    // Random traffic against a reference memory
    pool[0] = 17'h0A5C0; pool[1] = 17'h0A5C1; pool[2] = 17'h1A5C2;
    pool[3] = 17'h0A5FF; pool[4] = 17'h10000; pool[5] = 17'h0F00F;
    for (int t = 0; t < 30; t++) begin
      port = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      a    = pool[$urandom_range(0, 5)];
      wd   = 8'($urandom);
      exp_rd = ref_mem.exists(a) ? ref_mem[a] : init_byte(24'(a));
      run_check($sformatf("rnd%0d", t), port, we, a, wd, we ? 20 : 24, we ? 20 : 16,
                we ? wd : exp_rd);
      if (we) ref_mem[a] = wd;
    end

    chk("sram_oe_protocol", 64'(oe_viol), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1);
  end

endmodule
